lc3_fetch_stage: RTL and testbench

//  - LC3 instruction fetch stage; sits directly upstream of the decode stage.
//  - Owns the PC and issues one-at-a-time requests to instruction memory.
//  - Presents {instr_mem_dout, npc_out} to decode with a valid/ready handshake.
//  - Redirects on a taken branch/JMP resolved downstream and squashes wrong-path fetches.

---
 rtl/lc3_pkg.sv | 35 +++
 rtl/lc3_fetch_stage.sv | 148 ++++++++++++++
 tb/tb_lc3_fetch_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// ---------------------------------------------------------------------------
// lc3_pkg
//  Definitions shared by the LC3 pipeline stages.
//  - lc3_word_t     : 16-bit machine word (instructions, addresses, data)
//  - LC3_RESET_PC   : PC loaded on reset
//  - OP_*           : opcode field values (instr[15:12]), shared with decode
//  - fetch_state_e  : fetch stage FSM states
// ---------------------------------------------------------------------------
package lc3_pkg;

   typedef logic [15:0] lc3_word_t;

   parameter lc3_word_t LC3_RESET_PC = 16'h3000;

   // Opcode field values, instr[15:12]
   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_LDR = 4'b0110;
   localparam logic [3:0] OP_STR = 4'b0111;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;
   localparam logic [3:0] OP_LEA = 4'b1110;

   typedef enum logic [1:0] {
      S_REQ,    // issue a single-cycle request at pc
      S_WAIT,   // request outstanding, waiting for imem_ack
      S_HOLD    // instruction presented to decode, waiting for dec_ready
   } fetch_state_e;

endpackage

// File: rtl/lc3_fetch_stage.sv
// ---------------------------------------------------------------------------
// lc3_fetch_stage
//  LC3 instruction fetch. Owns the PC, issues one non-overlapped request at a
//  time to instruction memory and hands {instruction, PC+1} to decode over a
//  valid/ready handshake. A downstream redirect (br_taken) loads a new PC and
//  squashes any fetch that is in flight or held for decode.
//
//  Optional build macro: LC3_FETCH_PERF_EN adds the fetch_cnt / squash_cnt
//  performance counters and their output ports.
//
//  Ports
//   clk             in   rising-edge clock
//   rst             in   synchronous, active-high reset
//   br_taken        in   redirect request (1-cycle pulse)
//   taddr           in   redirect target PC
//   imem_req        out  instruction memory read request (1 cycle)
//   imem_addr       out  read address (equals pc)
//   imem_ack        in   read data valid, honoured only in S_WAIT
//   imem_rdata      in   read data
//   enable_decode   out  instr_mem_dout / npc_out valid
//   dec_ready       in   decode accepts the current instruction
//   instr_mem_dout  out  fetched instruction
//   npc_out         out  PC+1 of the fetched instruction (wraps)
//   pc              out  current fetch PC
//   fetch_cnt       out  [LC3_FETCH_PERF_EN] instructions transferred to decode
//   squash_cnt      out  [LC3_FETCH_PERF_EN] fetches discarded by redirects
// ---------------------------------------------------------------------------
module lc3_fetch_stage
   import lc3_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter logic [DATA_W-1:0] RESET_PC = LC3_RESET_PC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              br_taken,
   input  logic [DATA_W-1:0] taddr,
   output logic              imem_req,
   output logic [DATA_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              enable_decode,
   input  logic              dec_ready,
   output logic [DATA_W-1:0] instr_mem_dout,
   output logic [DATA_W-1:0] npc_out,
   output logic [DATA_W-1:0] pc
`ifdef LC3_FETCH_PERF_EN
   ,
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       squash_cnt
`endif
);

   localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

   fetch_state_e      state;
   logic              squash;   // the outstanding request belongs to a redirected-away path
   logic [DATA_W-1:0] pc_next;

   assign pc_next   = pc + ONE;   // wraps at 2^DATA_W, carry dropped
   assign imem_addr = pc;

   // NOTE: imem_req is decoded from the state register rather than registered
   // separately, so the request appears in the very first S_REQ cycle after
   // reset; masking with rst keeps it low while reset is held.
   assign imem_req  = (state == S_REQ) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_REQ;
         pc             <= RESET_PC;
         squash         <= 1'b0;
         enable_decode  <= 1'b0;
         instr_mem_dout <= '0;
         npc_out        <= '0;
      end else begin
         unique case (state)
            S_REQ: begin
               // The request went out this cycle no matter what; a redirect
               // now must discard whatever data it returns.
               if (br_taken) begin
                  pc     <= taddr;
                  squash <= 1'b1;
               end
               state <= S_WAIT;
            end

            S_WAIT: begin
               if (br_taken) begin
                  pc <= taddr;
                  if (imem_ack) begin
                     // Stale data consumed the outstanding request; refetch.
                     squash <= 1'b0;
                     state  <= S_REQ;
                  end else begin
                     squash <= 1'b1;
                  end
               end else if (imem_ack) begin
                  if (squash) begin
                     squash <= 1'b0;
                     state  <= S_REQ;
                  end else begin
                     instr_mem_dout <= imem_rdata;
                     npc_out        <= pc_next;
                     enable_decode  <= 1'b1;
                     state          <= S_HOLD;
                  end
               end
            end

            S_HOLD: begin
               // A redirect drops the held instruction even if decode is ready.
               if (br_taken) begin
                  pc            <= taddr;
                  enable_decode <= 1'b0;
                  state         <= S_REQ;
               end else if (enable_decode && dec_ready) begin
                  pc            <= pc_next;
                  enable_decode <= 1'b0;
                  state         <= S_REQ;
               end
            end

            default: state <= S_REQ;
         endcase
      end
   end

`ifdef LC3_FETCH_PERF_EN
   logic transfer;
   logic discard;

   assign transfer = (state == S_HOLD) && enable_decode && dec_ready && !br_taken;
   assign discard  = ((state == S_WAIT) && imem_ack && (squash || br_taken)) ||
                     ((state == S_HOLD) && br_taken);

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt  <= '0;
         squash_cnt <= '0;
      end else begin
         if (transfer) fetch_cnt  <= fetch_cnt + 32'd1;
         if (discard)  squash_cnt <= squash_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_lc3_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_lc3_fetch_stage
//  Directed bench for lc3_fetch_stage. Each vector gives the inputs to drive
//  for one cycle together with the outputs expected at that cycle's start.
//  Outputs are observed on the falling edge, then the vector's inputs are
//  applied for the next rising edge. The memory side is scripted directly in
//  the vectors (imem_ack / imem_rdata).
// ---------------------------------------------------------------------------
module tb_lc3_fetch_stage;
   import lc3_pkg::*;

   logic        clk;
   logic        rst;
   logic        br_taken;
   logic [15:0] taddr;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        enable_decode;
   logic        dec_ready;
   logic [15:0] instr_mem_dout;
   logic [15:0] npc_out;
   logic [15:0] pc;
`ifdef LC3_FETCH_PERF_EN
   logic [31:0] fetch_cnt;
   logic [31:0] squash_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic late_ack_ok = 1'b0;

   lc3_fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .br_taken       (br_taken),
      .taddr          (taddr),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .enable_decode  (enable_decode),
      .dec_ready      (dec_ready),
      .instr_mem_dout (instr_mem_dout),
      .npc_out        (npc_out),
      .pc             (pc)
`ifdef LC3_FETCH_PERF_EN
      ,
      .fetch_cnt      (fetch_cnt),
      .squash_cnt     (squash_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory protocol: an ack is only legal while the stage waits for one.
   always @(posedge clk) begin
      if (!rst && imem_ack && dut.state != S_WAIT && !late_ack_ok)
         $error("imem_ack outside S_WAIT at %0t", $time);
   end

   typedef struct {
      logic        rst;
      logic        br;
      logic [15:0] taddr;
      logic        ack;
      logic [15:0] rdata;
      logic        rdy;
      logic        e_req;
      logic [15:0] e_pc;
      logic        e_en;
      logic [15:0] e_instr;
      logic [15:0] e_npc;
   } vec_t;

   function automatic vec_t v(input logic r, input logic b, input logic [15:0] ta,
                              input logic a, input logic [15:0] rd, input logic rdy,
                              input logic req, input logic [15:0] p, input logic en,
                              input logic [15:0] ins, input logic [15:0] npc);
      vec_t t;
      t.rst = r;   t.br = b;     t.taddr = ta; t.ack = a;    t.rdata = rd; t.rdy = rdy;
      t.e_req = req; t.e_pc = p; t.e_en = en;  t.e_instr = ins; t.e_npc = npc;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Compare outputs now, drive this vector's inputs, advance one cycle.
   task automatic step(input string tag, input vec_t t);
      check({tag, ".imem_req"},       32'(imem_req),       32'(t.e_req));
      check({tag, ".pc"},             32'(pc),             32'(t.e_pc));
      if (t.e_req) check({tag, ".imem_addr"}, 32'(imem_addr), 32'(t.e_pc));
      check({tag, ".enable_decode"},  32'(enable_decode),  32'(t.e_en));
      check({tag, ".instr_mem_dout"}, 32'(instr_mem_dout), 32'(t.e_instr));
      check({tag, ".npc_out"},        32'(npc_out),        32'(t.e_npc));
      rst        = t.rst;
      br_taken   = t.br;
      taddr      = t.taddr;
      imem_ack   = t.ack;
      imem_rdata = t.rdata;
      dec_ready  = t.rdy;
      @(negedge clk);
   endtask

   vec_t tbl [19];

   initial begin
      // 1-cycle-ack memory with decode ready, then a 5-cycle decode stall,
      // then a 2-cycle-ack fetch.
      //             rst br taddr    ack rdata    rdy  req pc       en instr    npc
      tbl[0]  = v(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h3000, 0, 16'h0000, 16'h0000);
      tbl[1]  = v(0, 0, 16'h0000, 1, 16'h1021, 0,   0, 16'h3000, 0, 16'h0000, 16'h0000);
      tbl[2]  = v(0, 0, 16'h0000, 0, 16'h0000, 1,   0, 16'h3000, 1, 16'h1021, 16'h3001);
      tbl[3]  = v(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h3001, 0, 16'h1021, 16'h3001);
      tbl[4]  = v(0, 0, 16'h0000, 1, 16'h5260, 0,   0, 16'h3001, 0, 16'h1021, 16'h3001);
      tbl[5]  = v(0, 0, 16'h0000, 0, 16'h0000, 1,   0, 16'h3001, 1, 16'h5260, 16'h3002);
      tbl[6]  = v(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h3002, 0, 16'h5260, 16'h3002);
      tbl[7]  = v(0, 0, 16'h0000, 1, 16'h1261, 0,   0, 16'h3002, 0, 16'h5260, 16'h3002);
      tbl[8]  = v(0, 0, 16'h0000, 0, 16'h0000, 0,   0, 16'h3002, 1, 16'h1261, 16'h3003);
      tbl[9]  = v(0, 0, 16'h0000, 0, 16'h0000, 0,   0, 16'h3002, 1, 16'h1261, 16'h3003);
      tbl[10] = v(0, 0, 16'h0000, 0, 16'h0000, 0,   0, 16'h3002, 1, 16'h1261, 16'h3003);
      tbl[11] = v(0, 0, 16'h0000, 0, 16'h0000, 0,   0, 16'h3002, 1, 16'h1261, 16'h3003);
      tbl[12] = v(0, 0, 16'h0000, 0, 16'h0000, 0,   0, 16'h3002, 1, 16'h1261, 16'h3003);
      tbl[13] = v(0, 0, 16'h0000, 0, 16'h0000, 1,   0, 16'h3002, 1, 16'h1261, 16'h3003);
      tbl[14] = v(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h3003, 0, 16'h1261, 16'h3003);
      tbl[15] = v(0, 0, 16'h0000, 0, 16'h0000, 0,   0, 16'h3003, 0, 16'h1261, 16'h3003);
      tbl[16] = v(0, 0, 16'h0000, 1, 16'hE002, 0,   0, 16'h3003, 0, 16'h1261, 16'h3003);
      tbl[17] = v(0, 0, 16'h0000, 0, 16'h0000, 1,   0, 16'h3003, 1, 16'hE002, 16'h3004);
      tbl[18] = v(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h3004, 0, 16'hE002, 16'h3004);

      rst = 1'b1; br_taken = 1'b0; taddr = '0; imem_ack = 1'b0; imem_rdata = '0; dec_ready = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("reset.imem_req",       32'(imem_req),       32'h0);
      check("reset.pc",             32'(pc),             32'h3000);
      check("reset.enable_decode",  32'(enable_decode),  32'h0);
      check("reset.instr_mem_dout", 32'(instr_mem_dout), 32'h0);
      check("reset.npc_out",        32'(npc_out),        32'h0);
`ifdef LC3_FETCH_PERF_EN
      check("reset.fetch_cnt",      fetch_cnt,           32'd0);
      check("reset.squash_cnt",     squash_cnt,          32'd0);
`endif
      rst = 1'b0;
      #1;

      for (int i = 0; i < 19; i++) step($sformatf("r%0d", i), tbl[i]);

      // Reset while the 3004 request is outstanding; its ack shows up in the
      // first cycle after reset and must be ignored.
      step("h0",  v(1, 0, 16'h0000, 0, 16'h0000, 0,   0, 16'h3004, 0, 16'hE002, 16'h3004));
      late_ack_ok = 1'b1;
      step("h1",  v(0, 0, 16'h0000, 1, 16'hBEEF, 0,   0, 16'h3000, 0, 16'h0000, 16'h0000));
      late_ack_ok = 1'b0;
      step("h2",  v(0, 0, 16'h0000, 1, 16'h0E05, 0,   0, 16'h3000, 0, 16'h0000, 16'h0000));
      step("h3",  v(0, 0, 16'h0000, 0, 16'h0000, 1,   0, 16'h3000, 1, 16'h0E05, 16'h3001));

      // Redirect to 4000 while the 3001 ack is pending; ack arrives 2 cycles later.
      step("h4",  v(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h3001, 0, 16'h0E05, 16'h3001));
      step("h5",  v(0, 1, 16'h4000, 0, 16'h0000, 0,   0, 16'h3001, 0, 16'h0E05, 16'h3001));
      step("h6",  v(0, 0, 16'h0000, 0, 16'h0000, 0,   0, 16'h4000, 0, 16'h0E05, 16'h3001));
      step("h7",  v(0, 0, 16'h0000, 1, 16'hDEAD, 0,   0, 16'h4000, 0, 16'h0E05, 16'h3001));
      step("h8",  v(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h4000, 0, 16'h0E05, 16'h3001));
      step("h9",  v(0, 0, 16'h0000, 1, 16'h2A03, 0,   0, 16'h4000, 0, 16'h0E05, 16'h3001));

      // Redirect in S_HOLD with dec_ready=1: held instruction dropped, go to FFFF.
      step("h10", v(0, 1, 16'hFFFF, 0, 16'h0000, 1,   0, 16'h4000, 1, 16'h2A03, 16'h4001));
`ifdef LC3_FETCH_PERF_EN
      check("h11.fetch_cnt",  fetch_cnt,  32'd1);
      check("h11.squash_cnt", squash_cnt, 32'd2);
`endif
      step("h11", v(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'hFFFF, 0, 16'h2A03, 16'h4001));

      // Fetch at FFFF: npc wraps to 0000 and the next request is to 0000.
      step("h12", v(0, 0, 16'h0000, 1, 16'hC1C0, 0,   0, 16'hFFFF, 0, 16'h2A03, 16'h4001));
      step("h13", v(0, 0, 16'h0000, 0, 16'h0000, 1,   0, 16'hFFFF, 1, 16'hC1C0, 16'h0000));

      // Redirect in S_REQ: the issued request's data is discarded.
      step("h14", v(0, 1, 16'h5000, 0, 16'h0000, 0,   1, 16'h0000, 0, 16'hC1C0, 16'h0000));
      step("h15", v(0, 0, 16'h0000, 1, 16'h1234, 0,   0, 16'h5000, 0, 16'hC1C0, 16'h0000));
      step("h16", v(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h5000, 0, 16'hC1C0, 16'h0000));

      // Redirect and ack in the same S_WAIT cycle: data discarded, refetch at 6000.
      step("h17", v(0, 1, 16'h6000, 1, 16'h5555, 0,   0, 16'h5000, 0, 16'hC1C0, 16'h0000));
      step("h18", v(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h6000, 0, 16'hC1C0, 16'h0000));
      step("h19", v(0, 0, 16'h0000, 1, 16'h7777, 0,   0, 16'h6000, 0, 16'hC1C0, 16'h0000));
      step("h20", v(0, 0, 16'h0000, 0, 16'h0000, 1,   0, 16'h6000, 1, 16'h7777, 16'h6001));
`ifdef LC3_FETCH_PERF_EN
      check("h21.fetch_cnt",  fetch_cnt,  32'd3);
      check("h21.squash_cnt", squash_cnt, 32'd4);
`endif
      step("h21", v(0, 0, 16'h0000, 0, 16'h0000, 0,   1, 16'h6001, 0, 16'h7777, 16'h6001));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
